seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Multiplexed 7-segment display driver for the temperature-detect datapath; sits directly downstream of the binary-to-BCD converter and consumes its packed BCD word and one-cycle valid strobe. Latches each new BCD value, holds it in a frame-synchronous display register, and time-multiplexes the digits onto a shared active-low segment bus with per-digit active-low selects. Inter-digit ghost blanking, decimal-point insertion and optional leading-zero suppression are included.

## Interface
- DIGITS, 6, number of display digits; BCD input width is 4*DIGITS
- SCAN_CNT, 50_000, clock cycles per digit slot (1 ms at 50 MHz); must be ≥ 2
- GAP_CNT, 500, blanking cycles at the end of each slot; 0 ≤ GAP_CNT < SCAN_CNT
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- bcd_din  in  4*DIGITS  packed BCD, digit 0 (least significant) in bits [3:0]
- bcd_din_vld  in  1  one-cycle strobe, bcd_din valid
- dp_mask  in  DIGITS  decimal-point enable per digit, sampled with bcd_din
- sel  out  DIGITS  digit select, active-low, one-cold while driving
- seg  out  8  segments active-low; seg[7]=dp, seg[6:0]=g..a
- frame_done  out  1  one-cycle pulse at the end of the last digit slot

## Operation
- FSM states: IDLE, DRIVE, GAP.
- IDLE: after reset, no value received yet; sel and seg all ones. First bcd_din_vld loads the display register directly; next cycle enters DRIVE at digit 0 with slot counter 0.
- Slot counter counts 0..SCAN_CNT-1. DRIVE while count < SCAN_CNT-GAP_CNT, GAP for the remaining GAP_CNT cycles; if GAP_CNT=0, GAP is never entered.
- DRIVE: sel[d]=0 for current digit d, others 1; seg = decode(nibble d) with seg[7]=~dp_mask[d].
- GAP: sel all ones, seg all ones.
- At slot end, digit index increments; wraps DIGITS-1 → 0, asserting frame_done for that one cycle.
- Decode (seg[6:0], active-low): 0=40h 1=79h 2=24h 3=30h 4=19h 5=12h 6=02h 7=78h 8=00h 9=10h; any nibble A–F shows dash (3Fh).
- Double buffering: bcd_din_vld writes bcd_din/dp_mask into a shadow register and sets pending. At frame wrap, pending shadow is copied to the display register and pending clears. Display never changes mid-frame.
- vld in the same cycle as frame wrap: incoming value goes straight to the display register; pending cleared.
- Multiple vld within one frame: last one wins.

## Timing
- Reset values: sel all ones, seg all ones, frame_done 0, state IDLE, counters 0, pending 0, registers 0.
- sel, seg, frame_done are registered; first driven digit appears 2 cycles after the first vld (load, then DRIVE output register).
- Frame period = DIGITS*SCAN_CNT cycles; refresh rate is independent of input rate.
- Latency from vld to display: at most one frame + 1 cycle once scanning.
- rst mid-frame: outputs blank the next cycle, return to IDLE, displayed value discarded; needs a fresh vld.

## Configuration
- LEADING_ZERO_BLANK_EN defined: scanning from digit DIGITS-1 downward, each zero digit is blanked (seg all ones, sel still driven) until the first non-zero digit or a digit with its dp_mask bit set; digit 0 is never blanked.
- Undefined: all digits always decoded; zeros shown as "0".

## Structure
- Shared package: FSM state encoding (IDLE/DRIVE/GAP), segment pattern constants for 0–9 and dash, SEG_OFF constant (8'hFF).
- One sub-module: seg_decode, combinational nibble+dp → 8-bit active-low pattern, instantiated once on the muxed nibble.

## Test plan
Params for bench: DIGITS=6, SCAN_CNT=8, GAP_CNT=2.
- Reset then idle 100 cycles → sel=3Fh, seg=FFh throughout, frame_done never asserted.
- vld with bcd_din=24'h000251, dp_mask=6'b000010 → 2 cycles later sel=3Eh seg=F9h for 6 cycles, blank 2 cycles, then sel=3Dh seg=12h (5, dp lit); frame_done every 48 cycles.
- Same input with LEADING_ZERO_BLANK_EN → digits 3–5 seg=FFh; without macro → seg=C0h on those digits.
- vld 24'h000123 mid-frame → display changes only at the cycle after frame_done; vld coincident with wrap → new value shown on digit 0 of the very next frame.
- Nibble 4'hB in digit 2 → that slot seg=BFh (dash, dp off).
- rst asserted mid-DRIVE of digit 3 → next cycle sel=3Fh seg=FFh, IDLE until next vld.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared types and segment patterns for the multiplexed 7-segment scan driver.
// Segment patterns are active-low, bit order g..a.
package seg_scan_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  // Non-BCD nibbles (A-F) render as a dash so corrupt input is visible.
  function automatic logic [6:0] seg_pattern(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_pattern = SEG_0;
      4'd1:    seg_pattern = SEG_1;
      4'd2:    seg_pattern = SEG_2;
      4'd3:    seg_pattern = SEG_3;
      4'd4:    seg_pattern = SEG_4;
      4'd5:    seg_pattern = SEG_5;
      4'd6:    seg_pattern = SEG_6;
      4'd7:    seg_pattern = SEG_7;
      4'd8:    seg_pattern = SEG_8;
      4'd9:    seg_pattern = SEG_9;
      default: seg_pattern = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_driver_seg_decode.sv
// Combinational BCD nibble + decimal point to active-low 8-bit segment pattern.
module seg_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {~dp, seg_pattern(nibble)};

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with double-buffered display register.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int SCAN_CNT = 50_000,
  parameter int GAP_CNT  = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_din,
  input  logic                  bcd_din_vld,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int CW = $clog2(SCAN_CNT);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_CNT - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_CNT - GAP_CNT - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(DIGITS - 1);
  localparam bit            HAS_GAP    = (GAP_CNT != 0);

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dig;
  logic [DIGITS-1:0][3:0] disp_bcd, shadow_bcd;
  logic [DIGITS-1:0] disp_dp, shadow_dp;
  logic pending;

  logic slot_end, wrap, blank, fd_nxt;
  logic [7:0] dec_seg, seg_nxt;
  logic [DIGITS-1:0] sel_nxt;

  assign slot_end = (cnt == SLOT_LAST);
  assign wrap     = (state != IDLE) && slot_end && (dig == DIG_LAST);

  seg_decode u_dec (
    .nibble (disp_bcd[dig]),
    .dp     (disp_dp[dig]),
    .seg    (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // lz[i]: digit i and everything above it are zero with no dp lit.
  logic [DIGITS-1:0] lz;
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (disp_bcd[DIGITS-1] == 4'd0) && !disp_dp[DIGITS-1];
    for (int i = DIGITS - 2; i >= 1; i--)
      lz[i] = lz[i+1] && (disp_bcd[i] == 4'd0) && !disp_dp[i];
    lz[0] = 1'b0;
  end
  assign blank = lz[dig];
`else
  assign blank = 1'b0;
`endif

  // Outputs are computed from the current slot position and registered.
  always_comb begin
    state_nxt = state;
    sel_nxt   = '1;
    seg_nxt   = SEG_OFF;
    fd_nxt    = wrap;
    case (state)
      IDLE: if (bcd_din_vld) state_nxt = DRIVE;
      DRIVE: begin
        for (int i = 0; i < DIGITS; i++) sel_nxt[i] = (dig != DW'(i));
        seg_nxt = blank ? SEG_OFF : dec_seg;
        if (HAS_GAP && cnt == DRIVE_LAST) state_nxt = GAP;
      end
      GAP: if (slot_end) state_nxt = DRIVE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dig        <= '0;
      disp_bcd   <= '0;
      disp_dp    <= '0;
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      sel        <= '1;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      seg        <= seg_nxt;
      frame_done <= fd_nxt;
      if (state == IDLE) begin
        cnt <= '0;
        dig <= '0;
        if (bcd_din_vld) begin
          disp_bcd <= bcd_din;
          disp_dp  <= dp_mask;
        end
      end else begin
        cnt <= slot_end ? '0 : cnt + 1'b1;
        if (slot_end) dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
        // Display only changes at frame wrap; a coincident strobe bypasses the shadow.
        if (wrap) begin
          if (bcd_din_vld) begin
            disp_bcd <= bcd_din;
            disp_dp  <= dp_mask;
            pending  <= 1'b0;
          end else if (pending) begin
            disp_bcd <= shadow_bcd;
            disp_dp  <= shadow_dp;
            pending  <= 1'b0;
          end
        end else if (bcd_din_vld) begin
          shadow_bcd <= bcd_din;
          shadow_dp  <= dp_mask;
          pending    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: timeline-arithmetic reference model plus spot checks.
// Honors LEADING_ZERO_BLANK_EN when defined for the build.
module tb_seg_scan_driver;

  localparam int DIG   = 6;
  localparam int SCAN  = 8;
  localparam int GAPC  = 2;
  localparam int FRAME = DIG * SCAN;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [23:0]     bcd_din = '0;
  logic            bcd_din_vld = 1'b0;
  logic [5:0]      dp_mask = '0;
  logic [5:0]      sel;
  logic [7:0]      seg;
  logic            frame_done;

  int total = 0;
  int bad   = 0;

  // Reference model: position on the scan timeline plus display/shadow contents.
  bit          m_run  = 1'b0;
  int          m_pos  = 0;
  logic [23:0] m_disp = '0;
  logic [5:0]  m_dp   = '0;
  logic [23:0] m_sh   = '0;
  logic [5:0]  m_shdp = '0;
  bit          m_pend = 1'b0;
  logic [5:0]  exp_sel = 6'h3F;
  logic [7:0]  exp_seg = 8'hFF;
  logic        exp_fd  = 1'b0;

  seg_scan_driver #(.DIGITS(DIG), .SCAN_CNT(SCAN), .GAP_CNT(GAPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .bcd_din     (bcd_din),
    .bcd_din_vld (bcd_din_vld),
    .dp_mask     (dp_mask),
    .sel         (sel),
    .seg         (seg),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] pat(input logic [3:0] nib);
    case (nib)
      4'd0: pat = 7'h40; 4'd1: pat = 7'h79; 4'd2: pat = 7'h24; 4'd3: pat = 7'h30;
      4'd4: pat = 7'h19; 4'd5: pat = 7'h12; 4'd6: pat = 7'h02; 4'd7: pat = 7'h78;
      4'd8: pat = 7'h00; 4'd9: pat = 7'h10; default: pat = 7'h3F;
    endcase
  endfunction

  // Predicts outputs visible after the next edge, given inputs sampled at that edge.
  task automatic model_step(input logic r, input logic v, input logic [23:0] d, input logic [5:0] m);
    int dg, w;
    bit blk;
    exp_sel = 6'h3F; exp_seg = 8'hFF; exp_fd = 1'b0;
    if (r) begin
      m_run = 0; m_pos = 0; m_disp = '0; m_dp = '0; m_sh = '0; m_shdp = '0; m_pend = 0;
    end else if (!m_run) begin
      if (v) begin m_run = 1; m_pos = 0; m_disp = d; m_dp = m; end
    end else begin
      dg = (m_pos / SCAN) % DIG;
      w  = m_pos % SCAN;
      if (w < SCAN - GAPC) begin
        exp_sel = 6'h3F & ~(6'd1 << dg);
        blk = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (dg != 0) begin
          blk = 1'b1;
          for (int j = dg; j < DIG; j++) if (m_disp[4*j +: 4] != 4'd0 || m_dp[j]) blk = 1'b0;
        end
`endif
        exp_seg = blk ? 8'hFF : {~m_dp[dg], pat(m_disp[4*dg +: 4])};
      end
      exp_fd = (m_pos % FRAME == FRAME - 1);
      if (exp_fd) begin
        if (v) begin m_disp = d; m_dp = m; m_pend = 0; end
        else if (m_pend) begin m_disp = m_sh; m_dp = m_shdp; m_pend = 0; end
      end else if (v) begin
        m_sh = d; m_shdp = m; m_pend = 1;
      end
      m_pos++;
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [23:0] d, input logic [5:0] m);
    rst = r; bcd_din_vld = v; bcd_din = d; dp_mask = m;
    model_step(r, v, d, m);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 24'h0, 6'h0);
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 24'h0, 6'h0);
    cyc(1'b1, 1'b0, 24'h0, 6'h0);
    for (int i = 0; i < 100; i++) begin
      idle();
      total++;
      if ({sel, seg, frame_done} !== {6'h3F, 8'hFF, 1'b0}) begin
        bad++;
        $display("FAIL reset_idle cyc %0d: sel=%h seg=%h fd=%b want sel=3f seg=ff fd=0", i, sel, seg, frame_done);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] d3;
`ifdef LEADING_ZERO_BLANK_EN
    d3 = 8'hFF;
`else
    d3 = 8'hC0;
`endif
    cyc(1'b0, 1'b1, 24'h000251, 6'b000010);
    total++;
    if ({sel, seg} !== {6'h3F, 8'hFF}) begin
      bad++; $display("FAIL basic_load: sel=%h seg=%h want sel=3f seg=ff", sel, seg);
    end
    for (int i = 1; i <= 2 * FRAME; i++) begin
      idle();
      total++;
      if ({sel, seg, frame_done} !== {exp_sel, exp_seg, exp_fd}) begin
        bad++;
        $display("FAIL basic_model cyc %0d: sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b", i, sel, seg, frame_done, exp_sel, exp_seg, exp_fd);
      end
      if (i == 1 || i == 9 || i == 7 || i == 25) begin
        total++;
        if ((i == 1 && {sel, seg} !== {6'h3E, 8'hF9}) || (i == 7 && {sel, seg} !== {6'h3F, 8'hFF}) ||
            (i == 9 && {sel, seg} !== {6'h3D, 8'h12}) || (i == 25 && {sel, seg} !== {6'h37, d3})) begin
          bad++; $display("FAIL basic_spot cyc %0d: sel=%h seg=%h", i, sel, seg);
        end
      end
      total++;
      if (frame_done !== (i % FRAME == 0)) begin
        bad++; $display("FAIL basic_frame_done cyc %0d: fd=%b want %b", i, frame_done, (i % FRAME == 0));
      end
    end
  endtask

  task automatic test_midframe();
    bit seen_fd = 0, done = 0;
    cyc(1'b0, 1'b1, 24'h000999, 6'h0);
    idle();
    cyc(1'b0, 1'b1, 24'h000123, 6'h0);
    for (int i = 0; i < 120 && !done; i++) begin
      idle();
      total++;
      if ({sel, seg, frame_done} !== {exp_sel, exp_seg, exp_fd}) begin
        bad++;
        $display("FAIL midframe_model cyc %0d: sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b", i, sel, seg, frame_done, exp_sel, exp_seg, exp_fd);
      end
      if (seen_fd) begin
        total++; done = 1;
        if ({sel, seg} !== {6'h3E, 8'hB0}) begin
          bad++; $display("FAIL midframe_after_wrap: sel=%h seg=%h want sel=3e seg=b0", sel, seg);
        end
      end else if (exp_sel == 6'h3E) begin
        total++;
        if (seg !== 8'hF9) begin
          bad++; $display("FAIL midframe_held: seg=%h want f9", seg);
        end
      end
      if (exp_fd) seen_fd = 1;
    end
    if (!done) begin
      total++; bad++; $display("FAIL midframe_timeout: no frame wrap observed");
    end
  endtask

  task automatic test_wrap_vld();
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_pos % FRAME == FRAME - 1) found = 1;
      else idle();
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL wrap_timeout: wrap point not reached");
    end else begin
      cyc(1'b0, 1'b1, 24'h000987, 6'h0);
      if (frame_done !== 1'b1) begin
        bad++; $display("FAIL wrap_fd: fd=%b want 1", frame_done);
      end
      idle();
      total++;
      if ({sel, seg} !== {6'h3E, 8'hF8}) begin
        bad++; $display("FAIL wrap_direct: sel=%h seg=%h want sel=3e seg=f8", sel, seg);
      end
      for (int i = 0; i < FRAME; i++) begin
        idle();
        total++;
        if ({sel, seg, frame_done} !== {exp_sel, exp_seg, exp_fd}) begin
          bad++;
          $display("FAIL wrap_model cyc %0d: sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b", i, sel, seg, frame_done, exp_sel, exp_seg, exp_fd);
        end
      end
    end
  endtask

  task automatic test_dash();
    logic [23:0] d;
    logic [5:0]  m;
    int k = -1;
    d = 24'($urandom); d[11:8] = 4'hB;
    m = 6'($urandom);  m[2] = 1'b0;
    cyc(1'b0, 1'b1, d, m);
    for (int i = 0; i < 150 && k < FRAME; i++) begin
      idle();
      total++;
      if ({sel, seg, frame_done} !== {exp_sel, exp_seg, exp_fd}) begin
        bad++;
        $display("FAIL dash_model cyc %0d: sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b", i, sel, seg, frame_done, exp_sel, exp_seg, exp_fd);
      end
      if (k >= 0) k++;
      if (k == 17) begin
        total++;
        if ({sel, seg} !== {6'h3B, 8'hBF}) begin
          bad++; $display("FAIL dash_digit2: sel=%h seg=%h want sel=3b seg=bf", sel, seg);
        end
      end
      if (exp_fd && k < 0) k = 0;
    end
    total++;
    if (k < FRAME) begin
      bad++; $display("FAIL dash_timeout: k=%0d", k);
    end
  endtask

  task automatic test_random();
    logic v;
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 19) == 0);
      cyc(1'b0, v, 24'($urandom), 6'($urandom));
      total++;
      if ({sel, seg, frame_done} !== {exp_sel, exp_seg, exp_fd}) begin
        bad++;
        $display("FAIL random_model cyc %0d: sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b", i, sel, seg, frame_done, exp_sel, exp_seg, exp_fd);
      end
    end
  endtask

  task automatic test_rst_mid();
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_pos % FRAME == 3 * SCAN + 2) found = 1;
      else idle();
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL rst_mid_timeout: digit 3 slot not reached");
    end
    cyc(1'b1, 1'b0, 24'h0, 6'h0);
    total++;
    if ({sel, seg, frame_done} !== {6'h3F, 8'hFF, 1'b0}) begin
      bad++; $display("FAIL rst_mid_blank: sel=%h seg=%h fd=%b want sel=3f seg=ff fd=0", sel, seg, frame_done);
    end
    for (int i = 0; i < 20; i++) begin
      idle();
      total++;
      if ({sel, seg, frame_done} !== {6'h3F, 8'hFF, 1'b0}) begin
        bad++; $display("FAIL rst_mid_idle cyc %0d: sel=%h seg=%h fd=%b", i, sel, seg, frame_done);
      end
    end
    cyc(1'b0, 1'b1, 24'h000042, 6'h0);
    idle();
    total++;
    if ({sel, seg} !== {6'h3E, 8'hA4}) begin
      bad++; $display("FAIL rst_mid_restart: sel=%h seg=%h want sel=3e seg=a4", sel, seg);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe();
    test_wrap_vld();
    test_dash();
    test_random();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
